// File: rtl/figure_pkg.sv
// figure_pkg: shared motion-state encoding and default screen/figure geometry
// for the figure_ctl slice.
package figure_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } fig_state_t;

    localparam int unsigned H_RES_DEF     = 1024;
    localparam int unsigned V_RES_DEF     = 768;
    localparam int unsigned FIG_W_DEF     = 52;
    localparam int unsigned FIG_H_DEF     = 52;
    localparam int unsigned X_INIT_DEF    = 100;
    localparam int unsigned STEP_X_DEF    = 4;
    localparam int unsigned JUMP_V_DEF    = 16;
    localparam int unsigned GRAVITY_DEF   = 1;
    localparam int unsigned VMAX_FALL_DEF = 16;

    localparam int unsigned POS_W = 12;
    localparam int unsigned VY_W  = 8;

endpackage

// File: rtl/figure_ctl_rise_detect.sv
// rise_detect: registered 0->1 edge detector. Both history flops reset high
// so a level that is already high when reset releases is not seen as an edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_qq;

    // Two-stage history of the input level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q  <= 1'b1;
            d_qq <= 1'b1;
        end else begin
            d_q  <= d;
            d_qq <= d_q;
        end
    end

    assign rise = d_q & ~d_qq;

endmodule

// File: rtl/figure_ctl.sv
// figure_ctl: per-frame motion controller for one player figure.
// Optional feature: define FIGURE_DOUBLE_JUMP_EN to allow one extra jump
// while airborne (cleared on landing).
module figure_ctl
    import figure_pkg::*;
#(
    parameter int unsigned H_RES     = H_RES_DEF,
    parameter int unsigned V_RES     = V_RES_DEF,
    parameter int unsigned FIG_W     = FIG_W_DEF,
    parameter int unsigned FIG_H     = FIG_H_DEF,
    parameter int unsigned X_INIT    = X_INIT_DEF,
    parameter int unsigned STEP_X    = STEP_X_DEF,
    parameter int unsigned JUMP_V    = JUMP_V_DEF,
    parameter int unsigned GRAVITY   = GRAVITY_DEF,
    parameter int unsigned VMAX_FALL = VMAX_FALL_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_up,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic [1:0]  state
);

    localparam logic [11:0] GROUND_Y = 12'(V_RES - FIG_H);
    localparam logic [11:0] X_MAX    = 12'(H_RES - FIG_W);
    localparam logic [11:0] STEP     = 12'(STEP_X);
    localparam logic [7:0]  VJUMP    = 8'(JUMP_V);
    localparam logic [7:0]  GRAV     = 8'(GRAVITY);
    localparam logic [8:0]  VMAX     = 9'(VMAX_FALL);

    logic        tick;
    logic        key_rise;
    logic        jump_req;
    logic [7:0]  vy;
    fig_state_t  st;

    logic [11:0] x_next;
    logic [12:0] x_sum;
    logic [11:0] y_next;
    logic [7:0]  vy_next;
    fig_state_t  st_next;
    logic [7:0]  vy_dec;
    logic [8:0]  vy_sum;
    logic [7:0]  vy_fall;
    logic signed [12:0] y_up;
    logic signed [12:0] y_dn;

`ifdef FIGURE_DOUBLE_JUMP_EN
    logic dj_used;
    logic dj_next;
`endif

    rise_detect u_vsync_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vsync),
        .rise  (tick)
    );

    rise_detect u_key_up_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_up),
        .rise  (key_rise)
    );

    assign state = st;

    // Horizontal step with clamping to [0, X_MAX].
    always_comb begin
        x_next = pos_x;
        x_sum  = {1'b0, pos_x} + {1'b0, STEP};
        if (key_left && !key_right) begin
            x_next = (pos_x < STEP) ? '0 : pos_x - STEP;
        end else if (key_right && !key_left) begin
            x_next = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[11:0];
        end
    end

    // Vertical integration: jump launch, rise with ceiling, fall with landing.
    always_comb begin
        y_next  = pos_y;
        vy_next = vy;
        st_next = st;
`ifdef FIGURE_DOUBLE_JUMP_EN
        dj_next = dj_used;
`endif
        vy_dec  = (vy > GRAV) ? vy - GRAV : '0;
        vy_sum  = {1'b0, vy} + {1'b0, GRAV};
        vy_fall = (vy_sum > VMAX) ? VMAX[7:0] : vy_sum[7:0];
        y_up    = $signed({1'b0, pos_y}) - $signed({5'b0, vy});
        y_dn    = $signed({1'b0, pos_y}) + $signed({5'b0, vy_fall});

        case (st)
            GROUND: begin
                if (jump_req) begin
                    vy_next = VJUMP;
                    st_next = RISE;
                end
            end
            RISE: begin
                if (y_up < 13'sd0) begin
                    y_next  = '0;
                    vy_next = '0;
                    st_next = FALL;
                end else begin
                    y_next  = y_up[11:0];
                    vy_next = vy_dec;
                    if (vy_dec == '0) begin
                        st_next = FALL;
                    end
                end
            end
            FALL: begin
                if (y_dn >= $signed({1'b0, GROUND_Y})) begin
                    y_next  = GROUND_Y;
                    vy_next = '0;
                    st_next = GROUND;
`ifdef FIGURE_DOUBLE_JUMP_EN
                    dj_next = 1'b0;
`endif
                end else begin
                    y_next  = y_dn[11:0];
                    vy_next = vy_fall;
                end
            end
            default: begin
                st_next = GROUND;
            end
        endcase

`ifdef FIGURE_DOUBLE_JUMP_EN
        // Airborne relaunch overrides the normal rise/fall step for this tick.
        if ((st == RISE || st == FALL) && jump_req && !dj_used) begin
            y_next  = pos_y;
            vy_next = VJUMP;
            st_next = RISE;
            dj_next = 1'b1;
        end
`endif
    end

    // Sticky jump request; a key edge coincident with a tick survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_req <= 1'b0;
        end else if (tick) begin
            jump_req <= key_rise;
        end else if (key_rise) begin
            jump_req <= 1'b1;
        end
    end

    // Motion registers advance only on the frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x <= 12'(X_INIT);
            pos_y <= GROUND_Y;
            vy    <= '0;
            st    <= GROUND;
        end else if (tick) begin
            pos_x <= x_next;
            pos_y <= y_next;
            vy    <= vy_next;
            st    <= st_next;
        end
    end

`ifdef FIGURE_DOUBLE_JUMP_EN
    // Double-jump token, consumed by an airborne relaunch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dj_used <= 1'b0;
        end else if (tick) begin
            dj_used <= dj_next;
        end
    end
`endif

endmodule
